// File: rtl/turn_ctrl_if.sv
// Control/status bundle between the turn sequencer and its keypad / data_path neighbours.
// The slave side is the sequencer; the master side drives picks, start and data_path results.
interface turn_ctrl_if;
  logic       start;
  logic [1:0] N;
  logic       pick_valid;
  logic [3:0] pick_idx;
  logic       go;
  logic       W;
  logic [3:0] sel_idx;
  logic       check_req;
  logic       move_pulse;
  logic       statecombo_next_turn;
  logic [1:0] T;
  logic       reveal;
  logic       win;
  logic [1:0] winner;
  logic       pick_err;
  logic [2:0] state;

  modport master (
    output start, N, pick_valid, pick_idx, go, W,
    input  sel_idx, check_req, move_pulse, statecombo_next_turn, T,
           reveal, win, winner, pick_err, state
  );

  modport slave (
    input  start, N, pick_valid, pick_idx, go, W,
    output sel_idx, check_req, move_pulse, statecombo_next_turn, T,
           reveal, win, winner, pick_err, state
  );
endinterface

// File: rtl/turn_ctrl.sv
// Turn sequencer for Chicken Cha-Cha-Cha: accepts tile picks, asks data_path for a match,
// then advances the chicken, passes the turn after a timed reveal, or declares a winner.
module turn_ctrl #(
  parameter int NUM_TILES     = 12,
  parameter int REVEAL_CYCLES = 50_000_000
) (
  input logic        clk,
  input logic        rst,
  turn_ctrl_if.slave bus
);

  localparam int              CW          = $clog2(REVEAL_CYCLES + 1);
  localparam logic [4:0]      TILE_LIMIT  = 5'(NUM_TILES);
  localparam logic [CW-1:0]   REVEAL_LOAD = CW'(REVEAL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_PICK = 3'd1,
    S_CHECK     = 3'd2,
    S_SAMPLE    = 3'd3,
    S_MOVE      = 3'd4,
    S_WINCHK    = 3'd5,
    S_REVEAL    = 3'd6,
    S_WIN       = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           n_lat_q, n_lat_d;
  logic [1:0]           t_q, t_d;
  logic [1:0]           winner_q, winner_d;
  logic [3:0]           sel_idx_q, sel_idx_d;
  logic [NUM_TILES-1:0] used_q, used_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pick_err_q, pick_err_d;
  logic [NUM_TILES-1:0] pick_onehot;
  logic                 pick_ok;

  // One-hot decode keeps out-of-range indices from ever touching the used mask.
  for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_onehot
    assign pick_onehot[gi] = (bus.pick_idx == 4'(gi));
  end

  assign pick_ok = ({1'b0, bus.pick_idx} < TILE_LIMIT) && ((used_q & pick_onehot) == '0);

  always_comb begin
    state_d    = state_q;
    n_lat_d    = n_lat_q;
    t_d        = t_q;
    winner_d   = winner_q;
    sel_idx_d  = sel_idx_q;
    used_d     = used_q;
    cnt_d      = cnt_q;
    pick_err_d = 1'b0;

    case (state_q)
      S_IDLE, S_WIN: begin
        if (bus.start) begin
          n_lat_d = bus.N;
          t_d     = 2'd0;
          used_d  = '0;
          state_d = S_WAIT_PICK;
        end
      end
      S_WAIT_PICK: begin
        if (bus.pick_valid) begin
          if (pick_ok) begin
            sel_idx_d = bus.pick_idx;
            used_d    = used_q | pick_onehot;
            state_d   = S_CHECK;
          end else begin
            pick_err_d = 1'b1;
          end
        end
      end
      S_CHECK:  state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (bus.go) begin
          state_d = S_MOVE;
        end else begin
          cnt_d   = REVEAL_LOAD;
          state_d = S_REVEAL;
        end
      end
      S_MOVE:   state_d = S_WINCHK;
      S_WINCHK: begin
        if (bus.W) begin
          winner_d = t_q;
          state_d  = S_WIN;
        end else begin
          state_d = S_WAIT_PICK;
        end
      end
      S_REVEAL: begin
        if (cnt_q == '0) begin
          t_d     = (t_q == n_lat_q) ? 2'd0 : t_q + 2'd1;
          used_d  = '0;
          state_d = S_WAIT_PICK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_lat_q    <= 2'd0;
      t_q        <= 2'd0;
      winner_q   <= 2'd0;
      sel_idx_q  <= 4'd0;
      used_q     <= '0;
      cnt_q      <= '0;
      pick_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_lat_q    <= n_lat_d;
      t_q        <= t_d;
      winner_q   <= winner_d;
      sel_idx_q  <= sel_idx_d;
      used_q     <= used_d;
      cnt_q      <= cnt_d;
      pick_err_q <= pick_err_d;
    end
  end

  // Single-cycle strobes are decoded straight from the state so they cannot outlive it.
  assign bus.check_req            = (state_q == S_CHECK);
  assign bus.move_pulse           = (state_q == S_MOVE);
  assign bus.reveal               = (state_q == S_REVEAL);
  assign bus.win                  = (state_q == S_WIN);
  assign bus.statecombo_next_turn = (state_q == S_REVEAL) && (cnt_q == '0);
  assign bus.sel_idx              = sel_idx_q;
  assign bus.T                    = t_q;
  assign bus.winner               = winner_q;
  assign bus.pick_err             = pick_err_q;
  assign bus.state                = state_q;

endmodule

// File: tb/tb_turn_ctrl.sv
// Randomized bench for turn_ctrl; a game-level model predicts every output cycle by cycle.
module tb_turn_ctrl;
  localparam int NT = 12;
  localparam int RC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  turn_ctrl_if bus();

  turn_ctrl #(.NUM_TILES(NT), .REVEAL_CYCLES(RC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Game model: whose turn, how many players, which tiles are gone, and who won.
  int        m_T, m_N, m_sel, m_winner;
  bit        m_idle, m_win;
  bit [15:0] m_used;

  logic [16:0] exp_v;

  function automatic logic [16:0] pack(input int st, input int t, input int sel,
                                       input bit cr, input bit mp, input bit nt,
                                       input bit rv, input bit wn, input int winr,
                                       input bit pe);
    return {3'(st), 2'(t), 4'(sel), cr, mp, nt, rv, wn, 2'(winr), pe};
  endfunction

  function automatic logic [16:0] observed();
    return {bus.state, bus.T, bus.sel_idx, bus.check_req, bus.move_pulse,
            bus.statecombo_next_turn, bus.reveal, bus.win, bus.winner, bus.pick_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idle = 1'b1; m_win = 1'b0; m_T = 0; m_N = 0; m_sel = 0; m_winner = 0; m_used = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.start = 1'b0; bus.pick_valid = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic start_game(input int n);
    $display("[TB] start N=%0d", n);
    bus.N = 2'(n); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    if (m_idle || m_win) begin
      m_N = n; m_T = 0; m_used = '0; m_idle = 1'b0; m_win = 1'b0;
    end
    exp_v = pack(1, m_T, m_sel, 0, 0, 0, 0, 0, m_winner, 0);
    n_tests++;
    if (observed() !== exp_v) begin
      n_fail++; $display("FAIL start: got %h expected %h", observed(), exp_v);
    end
    bus.N = 2'($urandom);
  endtask

  // Full transaction for one pick: accept/reject, match/mismatch, win or turn hand-off.
  task automatic run_pick(input int idx, input bit g, input bit w);
    bit acc;
    acc = !m_win && (idx < NT) && !m_used[idx];
    $display("[TB] pick idx=%0d go=%0d W=%0d T=%0d accept=%0d", idx, g, w, m_T, acc);
    bus.N = 2'($urandom);
    bus.pick_idx = 4'(idx); bus.pick_valid = 1'b1;
    step();
    bus.pick_valid = 1'b0; bus.pick_idx = 4'($urandom);
    if (m_win) begin
      exp_v = pack(7, m_T, m_sel, 0, 0, 0, 0, 1, m_winner, 0);
      n_tests++;
      if (observed() !== exp_v) begin
        n_fail++; $display("FAIL pick_in_win: got %h expected %h", observed(), exp_v);
      end
      return;
    end
    if (!acc) begin
      exp_v = pack(1, m_T, m_sel, 0, 0, 0, 0, 0, m_winner, 1);
      n_tests++;
      if (observed() !== exp_v) begin
        n_fail++; $display("FAIL pick_err_pulse: got %h expected %h", observed(), exp_v);
      end
      step();
      exp_v = pack(1, m_T, m_sel, 0, 0, 0, 0, 0, m_winner, 0);
      n_tests++;
      if (observed() !== exp_v) begin
        n_fail++; $display("FAIL pick_err_clear: got %h expected %h", observed(), exp_v);
      end
      return;
    end
    m_used[idx] = 1'b1;
    m_sel = idx;
    exp_v = pack(2, m_T, m_sel, 1, 0, 0, 0, 0, m_winner, 0);
    n_tests++;
    if (observed() !== exp_v) begin
      n_fail++; $display("FAIL check_cycle: got %h expected %h", observed(), exp_v);
    end
    step();
    bus.go = g;
    exp_v = pack(3, m_T, m_sel, 0, 0, 0, 0, 0, m_winner, 0);
    n_tests++;
    if (observed() !== exp_v) begin
      n_fail++; $display("FAIL sample_cycle: got %h expected %h", observed(), exp_v);
    end
    step();
    bus.go = 1'($urandom);
    if (g) begin
      exp_v = pack(4, m_T, m_sel, 0, 1, 0, 0, 0, m_winner, 0);
      n_tests++;
      if (observed() !== exp_v) begin
        n_fail++; $display("FAIL move_cycle: got %h expected %h", observed(), exp_v);
      end
      step();
      bus.W = w;
      exp_v = pack(5, m_T, m_sel, 0, 0, 0, 0, 0, m_winner, 0);
      n_tests++;
      if (observed() !== exp_v) begin
        n_fail++; $display("FAIL winchk_cycle: got %h expected %h", observed(), exp_v);
      end
      step();
      bus.W = 1'($urandom);
      if (w) begin
        m_win = 1'b1; m_winner = m_T;
      end
      exp_v = pack(w ? 7 : 1, m_T, m_sel, 0, 0, 0, 0, w, m_winner, 0);
      n_tests++;
      if (observed() !== exp_v) begin
        n_fail++; $display("FAIL after_match: got %h expected %h", observed(), exp_v);
      end
    end else begin
      for (int k = 0; k < RC; k++) begin
        exp_v = pack(6, m_T, m_sel, 0, 0, (k == RC - 1), 1, 0, m_winner, 0);
        n_tests++;
        if (observed() !== exp_v) begin
          n_fail++; $display("FAIL reveal_cycle%0d: got %h expected %h", k, observed(), exp_v);
        end
        step();
      end
      m_T = (m_T + 1) % (m_N + 1);
      m_used = '0;
      exp_v = pack(1, m_T, m_sel, 0, 0, 0, 0, 0, m_winner, 0);
      n_tests++;
      if (observed() !== exp_v) begin
        n_fail++; $display("FAIL turn_passed: got %h expected %h", observed(), exp_v);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.start = 1'($urandom); bus.pick_valid = 1'($urandom);
      bus.pick_idx = 4'($urandom); bus.go = 1'($urandom); bus.W = 1'($urandom);
      step();
      n_tests++;
      if (observed() !== 17'd0) begin
        n_fail++; $display("FAIL reset_hold: got %h expected %h", observed(), 17'd0);
      end
    end
    rst = 1'b0; bus.start = 1'b0; bus.pick_valid = 1'b0;
    model_reset();
    step();
    n_tests++;
    if (observed() !== 17'd0) begin
      n_fail++; $display("FAIL reset_idle: got %h expected %h", observed(), 17'd0);
    end
    start_game(2);
  endtask

  task automatic test_match();
    run_pick(5, 1'b1, 1'b0);
    run_pick(5, 1'b1, 1'b0);
  endtask

  task automatic test_mismatch_wrap();
    do_reset();
    start_game(1);
    run_pick(3, 1'b0, 1'b0);
    run_pick(3, 1'b0, 1'b0);
    run_pick(3, 1'b1, 1'b0);
  endtask

  task automatic test_invalid();
    run_pick(12, 1'b1, 1'b0);
    run_pick(15, 1'b1, 1'b0);
  endtask

  task automatic test_win();
    do_reset();
    start_game(2);
    run_pick(0, 1'b0, 1'b0);
    run_pick(1, 1'b1, 1'b1);
    run_pick(2, 1'b1, 1'b0);
    start_game(3);
  endtask

  task automatic test_reset_reveal();
    do_reset();
    start_game(3);
    $display("[TB] pick idx=7 go=0 with reset during reveal");
    bus.pick_idx = 4'd7; bus.pick_valid = 1'b1;
    step();
    bus.pick_valid = 1'b0;
    step();
    bus.go = 1'b0;
    step();
    step();
    exp_v = pack(6, 0, 7, 0, 0, 0, 1, 0, 0, 0);
    n_tests++;
    if (observed() !== exp_v) begin
      n_fail++; $display("FAIL reveal_cycle2: got %h expected %h", observed(), exp_v);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < RC + 2; i++) begin
      n_tests++;
      if (observed() !== 17'd0) begin
        n_fail++; $display("FAIL reset_mid_reveal%0d: got %h expected %h", i, observed(), 17'd0);
      end
      step();
    end
  endtask

  task automatic test_exhaust();
    do_reset();
    start_game(0);
    for (int i = 0; i < NT; i++) run_pick(i, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) run_pick(int'($urandom_range(0, 15)), 1'b1, 1'b0);
  endtask

  task automatic test_random();
    do_reset();
    start_game(int'($urandom_range(0, 3)));
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) start_game(int'($urandom_range(0, 3)));
      else run_pick(int'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.N = 2'd0; bus.pick_valid = 1'b0;
    bus.pick_idx = 4'd0; bus.go = 1'b0; bus.W = 1'b0;
    test_reset();
    test_match();
    test_invalid();
    test_mismatch_wrap();
    test_win();
    test_reset_reveal();
    test_exhaust();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/turn_ctrl.md
# turn_ctrl

Turn-sequencing controller for the Chicken Cha-Cha-Cha board game. It accepts tile picks from the keypad front end, requests a match check from `data_path`, and samples `data_path`'s `go` (match) and `W` (win) results. It then either advances the current chicken, hands the turn to the next player via `statecombo_next_turn`, or declares a winner. It sits directly around `data_path`: it produces that block's control inputs and consumes its status outputs.

## Interface
Parameters:
- `NUM_TILES`, default 12: number of face-down tiles; valid pick indices are 0..NUM_TILES-1.
- `REVEAL_CYCLES`, default 50_000_000: cycles a mismatched tile stays revealed (1 s at 50 MHz); minimum 1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a new game (honoured in IDLE and WIN only).
- `N`  in  2  player count minus one (0..3 means 1..4 players); sampled only when a game begins.
- `pick_valid`  in  1  one-cycle pulse; a tile pick is present on `pick_idx`.
- `pick_idx`  in  4  index of the picked tile.
- `go`  in  1  match result from `data_path`; sampled in SAMPLE.
- `W`  in  1  win result from `data_path`; sampled in WINCHK.
- `sel_idx`  out  4  latched index of the accepted pick; drives the `data_path` tile lookup.
- `check_req`  out  1  high for exactly the one CHECK cycle.
- `move_pulse`  out  1  high for exactly the one MOVE cycle; tells `data_path` to advance the current player.
- `statecombo_next_turn`  out  1  one-cycle pulse when the turn passes to the next player.
- `T`  out  2  current player, 0..N_lat.
- `reveal`  out  1  high throughout REVEAL.
- `win`  out  1  high throughout WIN.
- `winner`  out  2  player that won; valid while `win` is high.
- `pick_err`  out  1  one-cycle pulse when a pick is rejected.
- `state`  out  3  FSM state encoding, for LED/debug.

## Operation
- States and encodings: IDLE=0, WAIT_PICK=1, CHECK=2, SAMPLE=3, MOVE=4, WINCHK=5, REVEAL=6, WIN=7.
- Internal registers:
  - `N_lat` (2 bits): player count latched at game start.
  - `used` (NUM_TILES-bit mask): tiles already picked this turn.
  - Reveal counter: ceil(log2(REVEAL_CYCLES+1)) bits.
- IDLE: on `start`, load `N_lat`<=`N`, set `T`<=0 and `used`<=0, go to WAIT_PICK.
- WAIT_PICK, on `pick_valid`:
  - Accept if `pick_idx` < NUM_TILES and `used[pick_idx]`==0: latch `sel_idx`, set `used[pick_idx]`, go to CHECK.
  - Otherwise pulse `pick_err` the next cycle and stay in WAIT_PICK.
- CHECK: assert `check_req`, go to SAMPLE unconditionally.
- SAMPLE: if `go`==1, go to MOVE; else load the reveal counter with REVEAL_CYCLES-1 and go to REVEAL.
- MOVE: assert `move_pulse`, go to WINCHK.
- WINCHK:
  - If `W`==1: `winner`<=`T`, go to WIN.
  - Else go to WAIT_PICK. The same player continues and `used` is kept.
- REVEAL: decrement the counter each cycle. On the cycle the counter is 0:
  - pulse `statecombo_next_turn`;
  - `T`<=(`T`==`N_lat`) ? 0 : `T`+1;
  - `used`<=0;
  - go to WAIT_PICK.
- WIN: hold `win` and `winner`. On `start`, begin a new game exactly as from IDLE.
- `start` is ignored in all other states. `pick_valid` is ignored outside WAIT_PICK and does not pulse `pick_err` there.
- When all tiles are used and no pick can be accepted, the FSM stays in WAIT_PICK; every further pick is rejected.

## Timing
- Reset: all outputs 0, `state`=IDLE, `used`=0, `N_lat`=0, counter 0.
- Accepted pick on cycle c:
  - CHECK in c+1 (`check_req`=1);
  - SAMPLE in c+2, where `go` is sampled. `data_path` presents `go` one cycle after `check_req`.
- Match path: MOVE in c+3, WINCHK in c+4 where `W` is sampled, then WAIT_PICK or WIN in c+5.
- Mismatch path:
  - REVEAL is entered in c+3; `reveal` is high for exactly REVEAL_CYCLES cycles.
  - `statecombo_next_turn` pulses in the last REVEAL cycle.
  - `T` updates and WAIT_PICK is entered on the following edge.
- `pick_err` pulses one cycle after the rejected `pick_valid`.
- `rst` asserted in any state, including mid-REVEAL, returns to the reset values on the next edge; no `statecombo_next_turn` pulse is emitted.
- `N` changing mid-game has no effect until the next `start`.

## Test plan
- Rule 1 — reset/start: with `N`=2, hold `rst` then pulse `start` → `state`=1, `T`=0; all pulses 0 during and after reset.
- Rule 2 — match, no win: pick 5 with `go`=1 and `W`=0 → `sel_idx`=5, `check_req` at c+1, `move_pulse` at c+3, WAIT_PICK at c+5, `T` still 0. Re-pick 5 → `pick_err`.
- Rule 3 — mismatch and wrap: `REVEAL_CYCLES`=4, `N`=1, `go`=0 → `reveal` high 4 cycles, then `statecombo_next_turn` pulse and `T`=1. Second mismatch → `T` wraps to 0 and `used` is cleared.
- Rule 4 — invalid pick: `pick_idx`=12, then 15 → `pick_err` each time, state stays 1, no `check_req`.
- Rule 5 — win: `T`=1, `go`=1, `W`=1 → `win`=1, `winner`=1, state 7. `pick_valid` is ignored there. `start` → new game with `T`=0.
- Rule 6 — reset mid-REVEAL: assert `rst` on REVEAL cycle 2 → IDLE next cycle, `reveal`=0, no turn pulse.
